// File: rtl/audio_pkg.sv
// Shared types and constants for the audio sample source.
package audio_pkg;

  localparam int ADDR_W_DEF     = 23;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = $clog2(BYTES_PER_WORD);
  localparam int SHIFT_W        = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQUEST,
    ST_WAIT_DATA,
    ST_WAIT_TICK,
    ST_EMIT
  } state_e;

endpackage

// File: rtl/vol_to_shift.sv
// Thermometer volume code to right-shift amount; the lowest set bit decides.
module vol_to_shift
  import audio_pkg::*;
(
  input  logic [7:0]         volume,
  output logic [SHIFT_W-1:0] shift,
  output logic               mute
);

  // Priority search from bit 0 upward; an all-zero code mutes the output.
  always_comb begin
    shift = '0;
    mute  = 1'b0;
    if (volume[0])                  shift = 3'd0;
    else if (volume[1])             shift = 3'd1;
    else if (volume[2])             shift = 3'd2;
    else if (volume[3])             shift = 3'd3;
    else if (volume[4])             shift = 3'd4;
    else if (volume[5])             shift = 3'd5;
    else if (volume[6] | volume[7]) shift = 3'd6;
    else                            mute  = 1'b1;
  end

endmodule

// File: rtl/audio_sample_source.sv
// Streams signed 8-bit samples from 32-bit memory words to a consumer,
// one sample per (synchronised) sample_tick, scaled by a volume code.
module audio_sample_source
  import audio_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     play,
  input  logic [ADDR_W-1:0]        start_addr,
  input  logic [ADDR_W-1:0]        end_addr,
  input  logic                     sample_tick,
  input  logic [7:0]               volume,
  output logic                     mem_read,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic                     mem_waitrequest,
  input  logic                     mem_readdatavalid,
  input  logic [31:0]              mem_readdata,
  output logic signed [7:0]        sample,
  output logic                     sample_start,
  input  logic                     consumer_finish,
  output logic                     busy,
  output logic                     done,
  output logic                     overrun
);

  localparam logic [BYTE_IDX_W-1:0] LAST_BYTE = BYTE_IDX_W'(BYTES_PER_WORD - 1);

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [ADDR_W-1:0]       end_q, end_d;
  logic [31:0]             word_q, word_d;
  logic [BYTE_IDX_W-1:0]   byte_idx_q, byte_idx_d;
  logic signed [7:0]       sample_q, sample_d;
  logic                    sample_start_q, sample_start_d;
  logic                    done_q, done_d;
  logic                    overrun_q, overrun_d;
  logic                    pend_q, pend_d;
  logic                    abort_q, abort_d;
  logic                    play_q, play_d;
  logic [2:0]              tick_sync_q, tick_sync_d;

  logic                    play_rise;
  logic                    tick_edge;
  logic signed [7:0]       cur_byte;
  logic [SHIFT_W-1:0]      vol_shift;
  logic                    vol_mute;

  vol_to_shift u_vol (
    .volume (volume),
    .shift  (vol_shift),
    .mute   (vol_mute)
  );

  // Arithmetic right shift keeps the sign; mute forces silence.
  function automatic logic signed [7:0] scale_sample(input logic signed [7:0] s,
                                                     input logic [SHIFT_W-1:0] sh,
                                                     input logic mute);
    if (mute) return 8'sd0;
    return s >>> sh;
  endfunction

  assign play_rise    = play & ~play_q;
  // Bits [1:0] are the two-flop synchroniser, bit 2 holds the previous value.
  assign tick_edge    = tick_sync_q[1] & ~tick_sync_q[2];
  assign mem_read     = (state_q == ST_REQUEST);
  assign mem_addr     = addr_q;
  assign busy         = (state_q != ST_IDLE);
  assign sample       = sample_q;
  assign sample_start = sample_start_q;
  assign done         = done_q;
  assign overrun      = overrun_q;

  // Select the byte due for playback; byte 0 goes out first.
  always_comb begin
    cur_byte = '0;
    case (byte_idx_q)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
  end

  // Next-state logic for the playback controller and tick bookkeeping.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    end_d          = end_q;
    word_d         = word_q;
    byte_idx_d     = byte_idx_q;
    sample_d       = sample_q;
    sample_start_d = 1'b0;
    done_d         = 1'b0;
    overrun_d      = overrun_q;
    abort_d        = abort_q;
    pend_d         = pend_q;
    play_d         = play;
    tick_sync_d    = {tick_sync_q[1:0], sample_tick};

    // Ticks only count while a playback is active. A fresh edge in the
    // EMIT cycle re-arms the flag instead of being lost or flagged as overrun.
    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
    end else begin
      if (state_q == ST_EMIT) pend_d = 1'b0;
      if (tick_edge) begin
        if (pend_q && (state_q != ST_EMIT)) overrun_d = 1'b1;
        pend_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (play_rise) begin
          overrun_d = 1'b0;
          end_d     = end_addr;
          addr_d    = start_addr;
          if (start_addr > end_addr) begin
            done_d = 1'b1;
          end else begin
            byte_idx_d = '0;
            state_d    = ST_REQUEST;
          end
        end
      end
      ST_REQUEST: begin
        // A read may not be withdrawn once issued; abort is remembered instead.
        if (!play) abort_d = 1'b1;
        if (!mem_waitrequest) state_d = ST_WAIT_DATA;
      end
      ST_WAIT_DATA: begin
        if (!play) abort_d = 1'b1;
        if (mem_readdatavalid) begin
          if (abort_q || !play) begin
            state_d = ST_IDLE;
          end else begin
            word_d     = mem_readdata;
            byte_idx_d = '0;
            state_d    = ST_WAIT_TICK;
          end
        end
      end
      ST_WAIT_TICK: begin
        if (!play)                            state_d = ST_IDLE;
        else if (pend_q && consumer_finish)   state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (!play) begin
          state_d = ST_IDLE;
        end else begin
          sample_d       = scale_sample(cur_byte, vol_shift, vol_mute);
          sample_start_d = 1'b1;
          if (byte_idx_q != LAST_BYTE) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = ST_WAIT_TICK;
          end else if (addr_q != end_q) begin
            // Compared before incrementing, so an all-ones end address never wraps.
            addr_d  = addr_q + 1'b1;
            state_d = ST_REQUEST;
          end else begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      addr_q         <= '0;
      byte_idx_q     <= '0;
      sample_q       <= '0;
      sample_start_q <= 1'b0;
      done_q         <= 1'b0;
      overrun_q      <= 1'b0;
      pend_q         <= 1'b0;
      abort_q        <= 1'b0;
      play_q         <= 1'b0;
      tick_sync_q    <= '0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      byte_idx_q     <= byte_idx_d;
      sample_q       <= sample_d;
      sample_start_q <= sample_start_d;
      done_q         <= done_d;
      overrun_q      <= overrun_d;
      pend_q         <= pend_d;
      abort_q        <= abort_d;
      play_q         <= play_d;
      tick_sync_q    <= tick_sync_d;
    end
  end

  // Data holding registers; always written before use, so no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
    end_q  <= end_d;
  end

endmodule

// File: tb/tb_audio_sample_source.sv
// Directed bench for audio_sample_source with a small Avalon-style memory model.
module tb_audio_sample_source;

  localparam int AW = 23;

  logic              clk = 1'b0;
  logic              reset;
  logic              play;
  logic [AW-1:0]     start_addr;
  logic [AW-1:0]     end_addr;
  logic              sample_tick;
  logic [7:0]        volume;
  logic              mem_read;
  logic [AW-1:0]     mem_addr;
  logic              mem_waitrequest;
  logic              mem_readdatavalid;
  logic [31:0]       mem_readdata;
  logic signed [7:0] sample;
  logic              sample_start;
  logic              consumer_finish;
  logic              busy;
  logic              done;
  logic              overrun;

  always #5 clk = ~clk;

  audio_sample_source #(.ADDR_W(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .play              (play),
    .start_addr        (start_addr),
    .end_addr          (end_addr),
    .sample_tick       (sample_tick),
    .volume            (volume),
    .mem_read          (mem_read),
    .mem_addr          (mem_addr),
    .mem_waitrequest   (mem_waitrequest),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_readdata      (mem_readdata),
    .sample            (sample),
    .sample_start      (sample_start),
    .consumer_finish   (consumer_finish),
    .busy              (busy),
    .done              (done),
    .overrun           (overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: wait_cfg stall cycles per request, data two cycles after accept.
  logic [31:0]   mem [0:63];
  int            wait_cfg = 0;
  int            waits    = 0;
  int            rsp_lat  = 0;
  int            read_cnt = 0;
  int            done_cnt = 0;
  bit            in_req   = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [31:0]   rsp_data = '0;
  logic [AW-1:0] addr_log [$];

  always @(negedge clk) begin
    mem_readdatavalid = 1'b0;
    if (rsp_lat > 0) begin
      rsp_lat--;
      if (rsp_lat == 0) begin
        mem_readdatavalid = 1'b1;
        mem_readdata      = rsp_data;
      end
    end
    if (mem_read) begin
      if (!in_req) begin
        in_req   = 1'b1;
        req_addr = mem_addr;
        waits    = wait_cfg;
      end else begin
        chk("stalled addr stable", 32'(mem_addr), 32'(req_addr));
      end
      if (waits > 0) begin
        mem_waitrequest = 1'b1;
        waits--;
      end else begin
        mem_waitrequest = 1'b0;
        in_req          = 1'b0;
        addr_log.push_back(mem_addr);
        rsp_data        = mem[mem_addr[5:0]];
        rsp_lat         = 2;
        read_cnt++;
      end
    end else begin
      if (in_req && !reset) chk("stalled read held", 32'(mem_read), 32'd1);
      in_req          = 1'b0;
      mem_waitrequest = 1'b0;
    end
  end

  always @(negedge clk) if (done) done_cnt++;

  // Raise a tick for two cycles, return the next emitted sample and its latency.
  task automatic do_tick(output logic [7:0] s, output int lat, output bit ok);
    s = '0; lat = 0; ok = 1'b0;
    sample_tick = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      @(posedge clk); #1;
      if (c == 2) sample_tick = 1'b0;
      if (sample_start) begin
        s = sample; lat = c; ok = 1'b1;
        break;
      end
    end
    sample_tick = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0]       vol;
    logic [31:0]      word;
    logic [3:0][7:0]  exp;   // exp[0] is the first sample played
  } vec_t;

  vec_t vecs [9];

  initial begin
    logic [7:0] s;
    int         lat;
    bit         ok;
    int         d0, r0;
    bit         seen;

    vecs[0] = '{8'hFF, 32'h807F01FF, 32'h807F01FF};
    vecs[1] = '{8'hFC, 32'h7F40C080, 32'h1F10F0E0};
    vecs[2] = '{8'h00, 32'h807F01FF, 32'h00000000};
    vecs[3] = '{8'h80, 32'h807F40C0, 32'hFE0101FF};
    vecs[4] = '{8'hF8, 32'h01FF7F80, 32'h00FF0FF0};
    vecs[5] = '{8'hE0, 32'h807F20E0, 32'hFC0301FF};
    vecs[6] = '{8'hFE, 32'h817F02FF, 32'hC03F01FF};
    vecs[7] = '{8'hF0, 32'h807F10F0, 32'hF80701FF};
    vecs[8] = '{8'hC0, 32'h7F7F7F80, 32'h010101FE};

    for (int i = 0; i < 64; i++) mem[i] = '0;
    reset = 1'b1; play = 1'b0; sample_tick = 1'b0; volume = 8'h00;
    start_addr = '0; end_addr = '0; consumer_finish = 1'b1;
    mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;

    // Reset state
    repeat (3) @(posedge clk); #1;
    chk("rst mem_read", 32'(mem_read), 32'd0);
    chk("rst mem_addr", 32'(mem_addr), 32'd0);
    chk("rst sample", {24'h0, sample}, 32'd0);
    chk("rst sample_start", 32'(sample_start), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single-word playback across volume codes
    for (int v = 0; v < 9; v++) begin
      mem[16] = vecs[v].word; volume = vecs[v].vol;
      start_addr = 23'h10; end_addr = 23'h10;
      d0 = done_cnt; r0 = read_cnt;
      play = 1'b1;
      for (int i = 0; i < 4; i++) begin
        do_tick(s, lat, ok);
        chk($sformatf("v%0d sample%0d arrived", v, i), 32'(ok), 32'd1);
        chk($sformatf("v%0d sample%0d value", v, i), 32'(s), 32'(vecs[v].exp[i]));
        if (i > 0) chk($sformatf("v%0d sample%0d latency", v, i), 32'(lat), 32'd5);
        repeat (3) @(posedge clk); #1;
        chk($sformatf("v%0d sample%0d held", v, i), {24'h0, sample}, 32'(s));
      end
      chk($sformatf("v%0d done count", v), 32'(done_cnt - d0), 32'd1);
      chk($sformatf("v%0d read count", v), 32'(read_cnt - r0), 32'd1);
      chk($sformatf("v%0d idle at end", v), 32'(busy), 32'd0);
      chk($sformatf("v%0d overrun", v), 32'(overrun), 32'd0);
      play = 1'b0;
      repeat (2) @(posedge clk); #1;
    end

    // Consumer busy delays emission; a second tick while pending is an overrun
    mem[16] = 32'h807F01FF; volume = 8'hFF;
    start_addr = 23'h10; end_addr = 23'h10;
    d0 = done_cnt;
    play = 1'b1;
    do_tick(s, lat, ok);
    chk("cons first sample", 32'(s), 32'h0FF);
    consumer_finish = 1'b0;
    sample_tick = 1'b1;
    seen = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (c == 2)  sample_tick = 1'b0;
      if (c == 10) sample_tick = 1'b1;
      if (c == 12) sample_tick = 1'b0;
      if (sample_start) seen = 1'b1;
    end
    chk("cons held off", 32'(seen), 32'd0);
    chk("cons overrun set", 32'(overrun), 32'd1);
    consumer_finish = 1'b1;
    ok = 1'b0; s = '0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (sample_start) begin s = sample; ok = 1'b1; break; end
    end
    chk("cons released", 32'(ok), 32'd1);
    chk("cons second sample", 32'(s), 32'h01);
    do_tick(s, lat, ok);
    chk("cons third sample", 32'(s), 32'h7F);
    do_tick(s, lat, ok);
    chk("cons fourth sample", 32'(s), 32'h80);
    repeat (2) @(posedge clk); #1;
    chk("cons done count", 32'(done_cnt - d0), 32'd1);
    chk("cons overrun sticky", 32'(overrun), 32'd1);
    play = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Two words with a stalling memory
    wait_cfg = 5;
    mem[32] = 32'h04030201; mem[33] = 32'h08070605; volume = 8'hFF;
    start_addr = 23'h20; end_addr = 23'h21;
    addr_log.delete();
    d0 = done_cnt; r0 = read_cnt;
    play = 1'b1;
    for (int i = 0; i < 8; i++) begin
      do_tick(s, lat, ok);
      chk($sformatf("two-word sample%0d", i), 32'(s), 32'(i + 1));
    end
    repeat (2) @(posedge clk); #1;
    chk("two-word reads", 32'(read_cnt - r0), 32'd2);
    chk("two-word log size", 32'(addr_log.size()), 32'd2);
    if (addr_log.size() == 2) begin
      chk("two-word addr0", 32'(addr_log[0]), 32'h20);
      chk("two-word addr1", 32'(addr_log[1]), 32'h21);
    end
    chk("two-word done", 32'(done_cnt - d0), 32'd1);
    chk("two-word overrun cleared", 32'(overrun), 32'd0);
    play = 1'b0;
    wait_cfg = 0;
    repeat (2) @(posedge clk); #1;

    // play dropped while waiting for a tick
    mem[16] = 32'h807F01FF; start_addr = 23'h10; end_addr = 23'h10;
    d0 = done_cnt;
    play = 1'b1;
    do_tick(s, lat, ok);
    chk("abort sample", 32'(s), 32'hFF);
    play = 1'b0;
    @(posedge clk); #1;
    chk("abort idle", 32'(busy), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("abort no done", 32'(done_cnt - d0), 32'd0);

    // Empty range: done pulse, no reads
    start_addr = 23'h05; end_addr = 23'h04;
    r0 = read_cnt; d0 = done_cnt;
    play = 1'b1;
    @(posedge clk); #1;
    chk("empty done", 32'(done), 32'd1);
    chk("empty busy", 32'(busy), 32'd0);
    chk("empty mem_read", 32'(mem_read), 32'd0);
    @(posedge clk); #1;
    chk("empty done pulse", 32'(done), 32'd0);
    repeat (3) @(posedge clk); #1;
    chk("empty reads", 32'(read_cnt - r0), 32'd0);
    chk("empty done count", 32'(done_cnt - d0), 32'd1);
    play = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Reset while the read is outstanding
    start_addr = 23'h10; end_addr = 23'h10;
    play = 1'b1;
    @(posedge clk); #1;
    chk("midrd requesting", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    chk("midrd waiting busy", 32'(busy), 32'd1);
    chk("midrd waiting no read", 32'(mem_read), 32'd0);
    reset = 1'b1; play = 1'b0;
    #1;
    chk("midrd sample", {24'h0, sample}, 32'd0);
    chk("midrd busy", 32'(busy), 32'd0);
    chk("midrd mem_read", 32'(mem_read), 32'd0);
    chk("midrd mem_addr", 32'(mem_addr), 32'd0);
    chk("midrd sample_start", 32'(sample_start), 32'd0);
    chk("midrd done", 32'(done), 32'd0);
    chk("midrd overrun", 32'(overrun), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (5) @(posedge clk); #1;
    chk("midrd late data ignored", 32'(busy), 32'd0);
    chk("midrd no sample", 32'(sample_start), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
